if_stage: RTL and testbench

- Instruction-fetch stage for the 5-stage MIPS pipeline: program counter, synchronous instruction-memory interface, and the IF/ID pipeline register.
- Consumes the hazard unit's stall/flush controls (PCWr, IFIDWr, IFIDRst) and the next-PC from the NPC unit.
- Produces the IF/ID fields that the ctrl unit and the hazard unit read in ID (IFIDIns gives Rs/Rt).
- Also keeps stall/flush event counters for performance debug.

---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/ifid_reg.sv | 27 ++
 rtl/if_stage.sv | 100 ++++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage:
// reset constants, FSM encoding and the IF/ID bundle.
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INS  = 32'h0000_0000;
    localparam int          DEF_CNT_W    = 32;

    typedef enum logic {
        IF_BOOT = 1'b0,
        IF_RUN  = 1'b1
    } if_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; a flush (bubble) takes priority
// over a normal load, otherwise the fields hold.
module ifid_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INS = DEF_NOP_INS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] pc,
    input  logic [31:0] ins,
    output ifid_t       q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '{pc: 32'd0, pc4: 32'd4, ins: NOP_INS, valid: 1'b0};
        end else if (flush) begin
            q <= '{pc: pc, pc4: pc + 32'd4, ins: NOP_INS, valid: 1'b0};
        end else if (load) begin
            q <= '{pc: pc, pc4: pc + 32'd4, ins: ins, valid: 1'b1};
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, boot FSM, synchronous
// instruction-memory addressing, IF/ID register and event counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INS  = DEF_NOP_INS,
    parameter int          CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWr,
    input  logic             IFIDWr,
    input  logic             IFIDRst,
    input  logic [31:0]      NPC,
    output logic [31:0]      im_addr,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      PC,
    output logic [31:0]      IFIDPC,
    output logic [31:0]      IFIDPCPLUS4,
    output logic [31:0]      IFIDIns,
    output logic             IFIDValid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    if_state_t        state;
    if_state_t        state_nxt;
    logic             run;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    ifid_t            ifid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        unique case (state)
            IF_BOOT: state_nxt = IF_RUN;
            IF_RUN:  run       = 1'b1;
            default: state_nxt = IF_BOOT;
        endcase
    end

    // Present the next PC early so the synchronous memory returns
    // the word for the new PC exactly when it becomes current.
    assign im_addr = (run && PCWr) ? align4(NPC) : pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (run && PCWr) begin
            pc_q <= align4(NPC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (run) begin
            if (!PCWr && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (IFIDRst && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    // BOOT clears IF/ID back to its reset bubble.
    ifid_reg #(
        .NOP_INS (NOP_INS)
    ) u_ifid (
        .clk   (clk),
        .rst   (rst || !run),
        .flush (IFIDRst),
        .load  (IFIDWr),
        .pc    (pc_q),
        .ins   (im_rdata),
        .q     (ifid)
    );

    assign PC          = pc_q;
    assign IFIDPC      = ifid.pc;
    assign IFIDPCPLUS4 = ifid.pc4;
    assign IFIDIns     = ifid.ins;
    assign IFIDValid   = ifid.valid;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed pipeline scenarios
// followed by randomized control traffic against a behavioural model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        PCWr;
    logic        IFIDWr;
    logic        IFIDRst;
    logic [31:0] NPC;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] PC;
    logic [31:0] IFIDPC;
    logic [31:0] IFIDPCPLUS4;
    logic [31:0] IFIDIns;
    logic        IFIDValid;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit          m_known = 0;
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_ins;
    logic        m_valid;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    if_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .PCWr        (PCWr),
        .IFIDWr      (IFIDWr),
        .IFIDRst     (IFIDRst),
        .NPC         (NPC),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .PC          (PC),
        .IFIDPC      (IFIDPC),
        .IFIDPCPLUS4 (IFIDPCPLUS4),
        .IFIDIns     (IFIDIns),
        .IFIDValid   (IFIDValid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // synchronous instruction memory
    always @(posedge clk) im_rdata <= word(im_addr);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // one clock: drive at negedge, check im_addr, advance model
    // at posedge, check registered outputs at next negedge
    task automatic cyc(input bit r, input bit pw, input bit iw,
                       input bit ir, input logic [31:0] npc);
        rst = r; PCWr = pw; IFIDWr = iw; IFIDRst = ir; NPC = npc;
        #1;
        if (m_known)
            check("im_addr", im_addr,
                  (!m_boot && pw) ? (npc & 32'hFFFF_FFFC) : m_pc);
        @(posedge clk);
        if (r) begin
            m_known = 1; m_boot = 1; m_pc = 32'h3000;
            m_ipc = 0; m_ipc4 = 4; m_ins = 0; m_valid = 0;
            m_stall = 0; m_flush = 0;
        end else if (m_boot) begin
            m_boot = 0;
            m_ipc = 0; m_ipc4 = 4; m_ins = 0; m_valid = 0;
        end else begin
            if (!pw) m_stall = sat1(m_stall);
            if (ir) m_flush = sat1(m_flush);
            if (ir || iw) begin
                m_ipc = m_pc;
                m_ipc4 = m_pc + 32'd4;
                m_ins = ir ? 32'd0 : word(m_pc);
                m_valid = !ir;
            end
            if (pw) m_pc = npc & 32'hFFFF_FFFC;
        end
        @(negedge clk);
        if (m_known) begin
            check("PC", PC, m_pc);
            check("IFIDPC", IFIDPC, m_ipc);
            check("IFIDPCPLUS4", IFIDPCPLUS4, m_ipc4);
            check("IFIDIns", IFIDIns, m_ins);
            check("IFIDValid", {31'd0, IFIDValid}, {31'd0, m_valid});
            check("stall_cnt", stall_cnt, m_stall);
            check("flush_cnt", flush_cnt, m_flush);
        end
    endtask

    initial begin
        rst = 1; PCWr = 0; IFIDWr = 0; IFIDRst = 0; NPC = 0;
        @(negedge clk);

        // reset, then boot
        cyc(1, 1, 1, 0, 32'h0);
        cyc(1, 1, 1, 0, 32'h0);
        check("rst_valid", {31'd0, IFIDValid}, 32'd0);
        check("rst_ipc4", IFIDPCPLUS4, 32'd4);
        rst = 0; PCWr = 1; IFIDWr = 1; NPC = 32'h3004;
        #1;
        check("boot_im_addr", im_addr, 32'h3000);
        cyc(0, 1, 1, 0, 32'h3004);
        check("boot_valid", {31'd0, IFIDValid}, 32'd0);

        // straight line, with a load-use stall after 3004
        cyc(0, 1, 1, 0, m_pc + 4);
        check("first_ipc", IFIDPC, 32'h3000);
        check("first_ins", IFIDIns, word(32'h3000));
        check("first_ipc4", IFIDPCPLUS4, 32'h3004);
        cyc(0, 1, 1, 0, m_pc + 4);
        check("line_ipc", IFIDPC, 32'h3004);
        cyc(0, 0, 0, 0, 32'hDEAD_BEEF);
        check("stall_ipc", IFIDPC, 32'h3004);
        check("stall_pc", PC, 32'h3008);
        check("stall_cnt1", stall_cnt, 32'd1);
        cyc(0, 1, 1, 0, m_pc + 4);
        check("resume_ipc", IFIDPC, 32'h3008);
        check("resume_ins", IFIDIns, word(32'h3008));
        cyc(0, 1, 1, 0, m_pc + 4);
        check("line_ipc4th", IFIDPC, 32'h300C);

        // jump flush
        check("pre_jump_pc", PC, 32'h3010);
        cyc(0, 1, 0, 1, 32'h3100);
        check("jump_ins", IFIDIns, 32'd0);
        check("jump_valid", {31'd0, IFIDValid}, 32'd0);
        check("jump_pc", PC, 32'h3100);
        check("jump_flush", flush_cnt, 32'd1);
        cyc(0, 1, 1, 0, m_pc + 4);
        check("target_ipc", IFIDPC, 32'h3100);
        check("target_ins", IFIDIns, word(32'h3100));

        // stall and flush together
        cyc(0, 0, 1, 1, 32'h0);
        check("both_valid", {31'd0, IFIDValid}, 32'd0);
        check("both_pc", PC, 32'h3104);
        check("both_stall", stall_cnt, 32'd2);
        check("both_flush", flush_cnt, 32'd2);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bit r, pw, iw, ir;
            logic [31:0] npc;
            r  = ($urandom_range(0, 99) == 0);
            pw = ($urandom_range(0, 3) != 0);
            iw = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 5) == 0);
            npc = ($urandom_range(0, 1) == 0) ? m_pc + 4 : $urandom;
            if (k % 97 == 0) npc = 32'hFFFF_FFFF;
            cyc(r, pw, iw, ir, npc);
        end

        // saturation
        cyc(1, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0);
        cyc(0, 1, 1, 0, m_pc + 4);
        force u_dut.stall_q = 32'hFFFF_FFFE;
        #1;
        release u_dut.stall_q;
        m_stall = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 32'h0);
        check("sat_stall", stall_cnt, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0, 32'h0);
        check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0, 32'h0);
        check("sat_clear", stall_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
